// File: rtl/gaussian_window_ctrl.sv
// Raster-scan sequencer for a 3x3 Gaussian smoothing stage.
// Walks a virtual (IMG_H+1) x (IMG_W+1) raster, keeps two line buffers and
// a 3x3 shift window, and emits one zero-padded window per image pixel
// through a registered valid/ready output.
//
// state  | meaning
// S_IDLE | waiting for start, no input accepted
// S_RUN  | stepping the virtual raster
// S_DRAIN| last step taken, waiting for the final window to leave
// S_DONE | one-cycle end-of-frame pulse
module gaussian_window_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic            win_valid,
  input  logic            win_ready,
  output logic [9*DW-1:0] win_data,
  output logic            win_sof,
  output logic            win_eol,
  output logic            win_eof,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] VC_LAST = CW'(IMG_W);
  localparam logic [RW-1:0] VR_LAST = RW'(IMG_H);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   vc_q, vc_d;
  logic [RW-1:0]   vr_q, vr_d;

  // lb1 holds row vr-1, lb2 holds row vr-2, indexed by virtual column
  logic [DW-1:0]   lb1_q [IMG_W+1];
  logic [DW-1:0]   lb2_q [IMG_W+1];
  // c0 = column vc-2, c1 = column vc-1; index is the tap row
  logic [DW-1:0]   c0_q [3];
  logic [DW-1:0]   c1_q [3];
  logic [DW-1:0]   col_new [3];

  logic            win_valid_q;
  logic [9*DW-1:0] win_data_q;
  logic            sof_q, eol_q, eof_q;

  logic            consuming, out_free, step, emit;
  logic [DW-1:0]   step_pix;
  logic [2:0]      row_ok, col_ok;
  logic [9*DW-1:0] win_d;

  assign consuming = (vr_q < VR_LAST) && (vc_q < VC_LAST);
  assign out_free  = !win_valid_q || win_ready;
  assign in_ready  = (state_q == S_RUN) && consuming && out_free;
  assign step      = (state_q == S_RUN) && out_free && (!consuming || in_valid);
  assign emit      = step && (vr_q != '0) && (vc_q != '0);
  assign step_pix  = consuming ? in_data : '0;

  assign col_new[0] = lb2_q[vc_q];
  assign col_new[1] = lb1_q[vc_q];
  assign col_new[2] = step_pix;

  // Padding is decided from the counters alone so stale buffer data never leaks.
  assign row_ok = {vr_q != VR_LAST, 1'b1, vr_q >= RW'(2)};
  assign col_ok = {vc_q != VC_LAST, 1'b1, vc_q >= CW'(2)};

  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign win_sof   = sof_q;
  assign win_eol   = eol_q;
  assign win_eof   = eof_q;

  // Assemble the masked window centred on (vr-1, vc-1).
  always_comb begin
    win_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (row_ok[i]) begin
        if (col_ok[0]) win_d[DW*(3*i)   +: DW] = c0_q[i];
        if (col_ok[1]) win_d[DW*(3*i+1) +: DW] = c1_q[i];
        if (col_ok[2]) win_d[DW*(3*i+2) +: DW] = col_new[i];
      end
    end
  end

  // Next-state and virtual raster counters.
  always_comb begin
    state_d = state_q;
    vc_d    = vc_q;
    vr_d    = vr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          vc_d    = '0;
          vr_d    = '0;
        end
      end
      S_RUN: begin
        if (step) begin
          if (vc_q == VC_LAST) begin
            vc_d = '0;
            if (vr_q == VR_LAST) begin
              vr_d    = '0;
              state_d = S_DRAIN;
            end else begin
              vr_d = vr_q + 1'b1;
            end
          end else begin
            vc_d = vc_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (out_free) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vc_q    <= '0;
      vr_q    <= '0;
    end else begin
      state_q <= state_d;
      vc_q    <= vc_d;
      vr_q    <= vr_d;
    end
  end

  // Output register: load on emission, otherwise drop valid once accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else if (emit) begin
      win_valid_q <= 1'b1;
      win_data_q  <= win_d;
      sof_q       <= (vr_q == RW'(1)) && (vc_q == CW'(1));
      eol_q       <= (vc_q == VC_LAST);
      eof_q       <= (vr_q == VR_LAST) && (vc_q == VC_LAST);
    end else if (win_ready) begin
      win_valid_q <= 1'b0;
    end
  end

  // Line buffers and shift window; contents need no reset.
  always_ff @(posedge clk) begin
    if (step) begin
      lb2_q[vc_q] <= lb1_q[vc_q];
      lb1_q[vc_q] <= step_pix;
      c0_q        <= c1_q;
      c1_q        <= col_new;
    end
  end

endmodule

// File: tb/tb_gaussian_window_ctrl.sv
// Bench for gaussian_window_ctrl on a 4x3 image with pixel(r,c) = 10r+c+1.
module tb_gaussian_window_ctrl;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;
  localparam logic [7:0] IMG [N] = '{8'd1, 8'd2, 8'd3, 8'd4,
                                     8'd11, 8'd12, 8'd13, 8'd14,
                                     8'd21, 8'd22, 8'd23, 8'd24};

  typedef struct {
    logic [7:0]  pix;
    logic [71:0] win;
    logic [2:0]  mk;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_ready;
  logic        win_valid, win_ready, win_sof, win_eol, win_eof, busy, done;
  logic [7:0]  in_data;
  logic [71:0] win_data;

  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vec [N];

  always #5 clk = ~clk;

  gaussian_window_ctrl #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_sof   (win_sof),
    .win_eol   (win_eol),
    .win_eof   (win_eof),
    .busy      (busy),
    .done      (done)
  );

  task automatic check_eq(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [71:0] model_win(input int rc, input int cc);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        int r;
        int c;
        r = rc - 1 + i;
        c = cc - 1 + j;
        if (r >= 0 && r < H && c >= 0 && c < W) w[8*(3*i+j) +: 8] = vec[r*W+c].pix;
      end
    end
    return w;
  endfunction

  function automatic logic [71:0] ctl_bits();
    return 72'({in_ready, win_valid, win_sof, win_eol, win_eof, busy, done});
  endfunction

  task automatic run_frame(input bit rdy_tog, input bit gaps, input bit start_mid,
                           input int abort_at, input logic [7:0] dxor);
    int px = 0;
    int wn = 0;
    int cyc = 0;
    int done_n = 0;
    int last_acc = -1;
    bit fin = 1'b0;
    bit seen = 1'b0;
    bit eof_acc = 1'b0;
    bit prev_stall = 1'b0;
    logic [71:0] prev_data = '0;
    logic [2:0]  prev_mk = '0;
    @(posedge clk); #1;
    while (!fin && cyc < 400) begin
      start     = (cyc == 0) || (start_mid && cyc == 6);
      in_valid  = (cyc == 0) || ((px < N) && !(gaps && $urandom_range(0, 99) < 40));
      in_data   = vec[(px < N) ? px : 0].pix ^ dxor;
      win_ready = rdy_tog ? (cyc % 3 == 2) : 1'b1;
      @(negedge clk);
      if (cyc == 0) begin
        check_eq("idle_in_ready", 72'(in_ready), 72'd0);
        check_eq("idle_busy", 72'(busy), 72'd0);
      end
      if (win_valid && !seen) begin
        seen = 1'b1;
        check_eq("first_win_latency", 72'(last_acc), 72'd5);
      end
      if (prev_stall) begin
        check_eq("hold_data", win_data, prev_data);
        check_eq("hold_markers", 72'({win_sof, win_eol, win_eof}), 72'(prev_mk));
      end
      if (win_valid && !win_ready) check_eq("in_ready_stalled", 72'(in_ready), 72'd0);
      prev_stall = win_valid && !win_ready;
      prev_data  = win_data;
      prev_mk    = {win_sof, win_eol, win_eof};
      last_acc   = (in_valid && in_ready) ? px : -1;
      if (in_valid && in_ready) px++;
      if (win_valid && win_ready) begin
        if (dxor == 8'd0 && wn < N) begin
          check_eq($sformatf("win%0d_data", wn), win_data, vec[wn].win);
          check_eq($sformatf("win%0d_markers", wn), 72'({win_sof, win_eol, win_eof}), 72'(vec[wn].mk));
          if (wn == 0)     check_eq("first_win_literal", win_data, 72'h0c_0b_00_02_01_00_00_00_00);
          if (wn == N - 1) check_eq("last_win_literal", win_data, 72'h00_00_00_00_18_17_00_0e_0d);
        end
        if (win_eof) eof_acc = 1'b1;
        wn++;
      end
      if (done) begin
        done_n++;
        check_eq("done_after_eof", 72'(eof_acc), 72'd1);
        fin = 1'b1;
      end
      if (abort_at > 0 && wn == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_eq("abort_ctl_zero", ctl_bits(), 72'd0);
        check_eq("abort_data_zero", win_data, 72'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        win_ready = 1'b0;
        return;
      end
      if (!fin) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check_eq("frame_completed", 72'(fin), 72'd1);
    check_eq("window_count", 72'(wn), 72'(N));
    check_eq("input_count", 72'(px), 72'(N));
    check_eq("done_pulses", 72'(done_n), 72'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      start     = 1'b0;
      in_valid  = 1'b1;
      win_ready = 1'b1;
      @(negedge clk);
      check_eq("post_busy", 72'(busy), 72'd0);
      check_eq("post_done", 72'(done), 72'd0);
      check_eq("post_in_ready", 72'(in_ready), 72'd0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    win_ready = 1'b0;
    for (int k = 0; k < N; k++) vec[k].pix = IMG[k];
    for (int k = 0; k < N; k++) begin
      vec[k].win = model_win(k / W, k % W);
      vec[k].mk  = {k == 0, (k % W) == W - 1, k == N - 1};
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_ctl_zero", ctl_bits(), 72'd0);
    check_eq("reset_data_zero", win_data, 72'd0);
    rst_n = 1'b1;

    run_frame(1'b0, 1'b0, 1'b0, 0, 8'h00);
    run_frame(1'b1, 1'b0, 1'b0, 0, 8'h00);
    run_frame(1'b0, 1'b1, 1'b0, 0, 8'h00);
    run_frame(1'b0, 1'b0, 1'b1, 0, 8'h00);
    run_frame(1'b0, 1'b0, 1'b0, 5, 8'ha5);
    run_frame(1'b0, 1'b0, 1'b0, 0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gaussian_window_ctrl.md
Name: gaussian_window_ctrl

Overview:
- Raster-scan sequencer in front of the 3x3 Gaussian smoothing datapath.
- Accepts one 8-bit pixel per cycle through a valid/ready stream and keeps two line buffers.
- Emits one complete zero-padded 3x3 window per image pixel, with frame/line markers, under output backpressure.
- Owns frame start/stop, so the convolution stage stays purely combinational.

Parameters:
IMG_W, 640, image width in pixels (>=2)
IMG_H, 480, image height in lines (>=2)
DW, 8, pixel width in bits

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame when IDLE, ignored otherwise
in_valid  in  1  input pixel valid
in_data  in  DW  input pixel, raster order
in_ready  out  1  input pixel accepted when in_valid&&in_ready
win_valid  out  1  window output valid
win_ready  in  1  downstream accepts window when win_valid&&win_ready
win_data  out  9*DW  window; byte k=3*i+j at [DW*k +: DW] = pixel(rc-1+i, cc-1+j), i,j in 0..2
win_sof  out  1  qualifies the window centred on (0,0)
win_eol  out  1  qualifies windows with centre column IMG_W-1
win_eof  out  1  qualifies the window centred on (IMG_H-1, IMG_W-1)
busy  out  1  high from the accepted start until done
done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all counters 0.
  - in_ready, win_valid, win_sof, win_eol, win_eof, busy and done are 0; win_data is 0.
  - Line-buffer contents are don't-care.
- State machine: IDLE -> RUN on start; RUN -> DRAIN after the last virtual step; DRAIN -> DONE when win_valid=0 (or is being accepted); DONE -> IDLE after one cycle. done=1 only in DONE. busy=1 in RUN and DRAIN.
- Virtual raster: RUN walks positions (vr,vc), vr in 0..IMG_H, vc in 0..IMG_W, column-fastest.
  - Column counter width clog2(IMG_W+1); row counter width clog2(IMG_H+1).
  - Positions with vr<IMG_H and vc<IMG_W consume one input pixel.
  - All other positions inject 0 and consume nothing.
- Step condition: at most one step per cycle. A step occurs when out_free and (consuming ? in_valid : 1), where out_free = !win_valid || win_ready.
- in_ready = RUN && position consumes && out_free. It is combinational from win_ready. in_ready is never asserted in IDLE, DRAIN or DONE.
- Line buffers: two buffers of depth IMG_W+1 plus a 3x3 shift window. Each step shifts the step pixel in at column vc.
- Emission: a step with vr>=1 and vc>=1 loads the output register with the window centred on (rc,cc)=(vr-1,vc-1). win_valid rises the cycle after that step.
- Padding: window taps with row -1, row IMG_H, column -1 or column IMG_W read 0. They are masked by the counters, never by stale buffer data.
- Output hold: win_valid, win_data and the markers are held stable while win_valid && !win_ready. A step whose emission coincides with win_ready=1 overwrites the register in the same cycle, giving a gapless stream.
- Frame length: exactly IMG_W*IMG_H windows per frame. Throughput is one step per cycle when unblocked, costing IMG_H+IMG_W+1 bubble steps per frame.
- Boundaries:
  - start while busy has no effect.
  - in_valid in IDLE is ignored and not consumed.
  - An in_valid gap stalls only consuming steps.
  - After win_eof the block accepts no further input until the next start.
- Reset mid-frame aborts immediately. The next frame after start is unaffected by any partial data.
- Arithmetic: counter wrap happens only at the virtual bounds (vc=IMG_W -> 0, vr++). There is no arithmetic on pixel data.

Test Plan:
1. IMG_W=4, IMG_H=3, pixel(r,c)=10r+c+1, win_ready=1, in_valid=1:
   - exactly 12 windows.
   - first window has win_sof=1; bytes0..8 = 0,0,0,0,1,2,0,11,12.
   - win_valid first rises the cycle after pixel(1,1) is accepted.
2. Same stimulus:
   - last window has win_eof=1 and win_eol=1; bytes = 13,14,0,23,24,0,0,0,0.
   - done pulses exactly once, after it is accepted.
   - busy=0 on the following cycle.
3. win_ready toggled in a 1-on/2-off pattern: window sequence identical to test 1; win_data held stable while stalled; in_ready=0 whenever the output is stalled.
4. Random in_valid gaps (~40%): output sequence identical to test 1; no pixel lost or duplicated (12 accepted inputs, 12 windows).
5. start pulsed during RUN: no restart; window count is still 12. start pulsed in IDLE with in_valid=1: in_ready=0 before start.
6. rst_n low after 5 windows, then a fresh start:
   - all outputs 0 during reset.
   - the new frame reproduces test 1 exactly, with first-window bytes unaffected by prior buffer contents.
